// File: rtl/axis_packet_store_forward.sv
// Store-and-forward AXI-Stream packet buffer: SDP RAM of {tlast,tdata} plus one output register.
// Define AXIS_PKT_DROP_OVERSIZE_EN to discard packets that alone overflow the RAM.
module axis_packet_store_forward #(
    parameter  int DSIZE = 64,
    parameter  int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             aclk,
    input  logic             rst,
    input  logic [DSIZE-1:0] s_axis_tdata,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [DSIZE-1:0] m_axis_tdata,
    output logic             m_axis_tlast,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [AW:0]      pkt_count,
    output logic             drop_pulse
);

    typedef enum logic {ST_ACCEPT, ST_DROP} state_t;

    state_t           r_state, w_state_nxt;
    logic [DSIZE:0]   r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr, r_cm_ptr, r_rd_ptr, w_used;
    logic [AW:0]      r_pkt_count;
    logic [DSIZE-1:0] r_m_tdata;
    logic             r_m_tlast, r_m_tvalid;
    logic             w_full, w_avail, w_load, w_m_hs, w_ready, w_wr_en;
    logic             w_pkt_in, w_pkt_out;
`ifdef AXIS_PKT_DROP_OVERSIZE_EN
    logic             w_rewind, w_drop_done, r_drop_pulse;
`endif

    assign w_used    = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_used == (AW+1)'(DEPTH));
    assign w_avail   = (r_cm_ptr != r_rd_ptr);
    assign w_m_hs    = r_m_tvalid && m_axis_tready;
    // Only committed words ever reach the output register, so no cut-through.
    assign w_load    = w_avail && (!r_m_tvalid || m_axis_tready);
    assign w_pkt_in  = w_wr_en && s_axis_tlast;
    assign w_pkt_out = w_m_hs && r_m_tlast;

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_wr_en     = 1'b0;
`ifdef AXIS_PKT_DROP_OVERSIZE_EN
        w_rewind    = 1'b0;
        w_drop_done = 1'b0;
`endif
        case (r_state)
            ST_ACCEPT: begin
`ifdef AXIS_PKT_DROP_OVERSIZE_EN
                // Full with nothing committed: the open packet can never fit, so swallow it.
                w_ready = !w_full || !w_avail;
                if (w_full && !w_avail && s_axis_tvalid && !rst) begin
                    w_rewind = 1'b1;
                    if (s_axis_tlast) w_drop_done = 1'b1;
                    else              w_state_nxt = ST_DROP;
                end else begin
                    w_wr_en = s_axis_tvalid && !w_full && !rst;
                end
`else
                w_ready = !w_full;
                w_wr_en = s_axis_tvalid && !w_full && !rst;
`endif
            end
`ifdef AXIS_PKT_DROP_OVERSIZE_EN
            ST_DROP: begin
                w_ready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast && !rst) begin
                    w_drop_done = 1'b1;
                    w_state_nxt = ST_ACCEPT;
                end
            end
`endif
            default: w_state_nxt = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state     <= ST_ACCEPT;
            r_wr_ptr    <= '0;
            r_cm_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_m_tdata   <= '0;
            r_m_tlast   <= 1'b0;
            r_m_tvalid  <= 1'b0;
            r_pkt_count <= '0;
`ifdef AXIS_PKT_DROP_OVERSIZE_EN
            r_drop_pulse <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (s_axis_tlast) r_cm_ptr <= r_wr_ptr + 1'b1;
            end
`ifdef AXIS_PKT_DROP_OVERSIZE_EN
            if (w_rewind) r_wr_ptr <= r_cm_ptr;
            r_drop_pulse <= w_drop_done;
`endif
            if (w_load) begin
                r_rd_ptr                <= r_rd_ptr + 1'b1;
                {r_m_tlast, r_m_tdata}  <= r_mem[r_rd_ptr[AW-1:0]];
                r_m_tvalid              <= 1'b1;
            end else if (w_m_hs) begin
                r_m_tvalid <= 1'b0;
            end
            if (w_pkt_in && !w_pkt_out)      r_pkt_count <= r_pkt_count + 1'b1;
            else if (!w_pkt_in && w_pkt_out) r_pkt_count <= r_pkt_count - 1'b1;
        end
    end

    assign s_axis_tready = w_ready && !rst;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tvalid = r_m_tvalid;
    assign pkt_count     = r_pkt_count;
`ifdef AXIS_PKT_DROP_OVERSIZE_EN
    assign drop_pulse    = r_drop_pulse;
`else
    assign drop_pulse    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_packet_store_forward.sv
// Bench for axis_packet_store_forward: queue-based packet model checked every cycle plus directed literals.
// Define AXIS_PKT_DROP_OVERSIZE_EN to also exercise the oversize-drop path.
module tb_axis_packet_store_forward;
    localparam int DSIZE = 32;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic             aclk = 1'b0, rst = 1'b1;
    logic [DSIZE-1:0] s_tdata = '0;
    logic             s_tlast = 1'b0, s_tvalid = 1'b0, m_tready = 1'b0;
    logic             s_axis_tready, m_axis_tlast, m_axis_tvalid, drop_pulse;
    logic [DSIZE-1:0] m_axis_tdata;
    logic [AW:0]      pkt_count;

    axis_packet_store_forward #(.DSIZE(DSIZE), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_tready),
        .pkt_count(pkt_count), .drop_pulse(drop_pulse)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc++;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        else n_pass++;
    endtask

    // Model: oq = beats of the open packet, cq = committed beats not yet emitted (with commit edge).
    logic [DSIZE:0]   oq[$], cq[$];
    int               cq_e[$];
    logic [DSIZE-1:0] log_d[$];
    bit               log_l[$];
    int               log_c[$];
    bit               live = 0, just_rst = 0, pulse_exp = 0;
    int               drop_cnt = 0, pkt_max = 0;
`ifdef AXIS_PKT_DROP_OVERSIZE_EN
    bit               drop_mode = 0;
`endif

    always @(negedge aclk) begin : mon
        bit ev, er, trig;
        int used, pk;
        if (rst) begin
            chk("rst_tready", s_axis_tready, 0);
            oq.delete(); cq.delete(); cq_e.delete();
            live = 1; just_rst = 1; pulse_exp = 0;
`ifdef AXIS_PKT_DROP_OVERSIZE_EN
            drop_mode = 0;
`endif
        end else if (live) begin
            // A beat is visible one edge after the edge that committed its packet.
            ev   = (cq.size() > 0) && (cq_e[0] < cyc);
            used = oq.size() + cq.size() - (ev ? 1 : 0);
            er   = used < DEPTH;
            trig = 0;
`ifdef AXIS_PKT_DROP_OVERSIZE_EN
            trig = (used == DEPTH) && (oq.size() == DEPTH);
            if (drop_mode || trig) er = 1;
`endif
            pk = 0;
            foreach (cq[i]) if (cq[i][DSIZE]) pk++;
            chk("s_tready", s_axis_tready, er);
            chk("m_tvalid", m_axis_tvalid, ev);
            chk("pkt_count", pkt_count, pk);
            chk("drop_pulse", drop_pulse, pulse_exp);
            if (ev) begin
                chk("m_tdata", m_axis_tdata, cq[0][DSIZE-1:0]);
                chk("m_tlast", m_axis_tlast, cq[0][DSIZE]);
            end
            if (just_rst) begin
                chk("rst_tdata", m_axis_tdata, 0);
                chk("rst_tlast", m_axis_tlast, 0);
            end
            just_rst = 0;
            if (drop_pulse) drop_cnt++;
            if (int'(pkt_count) > pkt_max) pkt_max = int'(pkt_count);
            pulse_exp = 0;
            if (ev && m_tready) begin
                log_d.push_back(cq[0][DSIZE-1:0]);
                log_l.push_back(cq[0][DSIZE]);
                log_c.push_back(cyc);
                void'(cq.pop_front());
                void'(cq_e.pop_front());
            end
            if (s_tvalid && er) begin
`ifdef AXIS_PKT_DROP_OVERSIZE_EN
                if (drop_mode || trig) begin
                    oq.delete();
                    drop_mode = !s_tlast;
                    pulse_exp = s_tlast;
                end else
`endif
                begin
                    oq.push_back({s_tlast, s_tdata});
                    if (s_tlast) begin
                        foreach (oq[i]) begin cq.push_back(oq[i]); cq_e.push_back(cyc + 1); end
                        oq.delete();
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    task automatic push(input logic [DSIZE-1:0] d, input logic l);
        bit rdy;
        int n;
        n = 0;
        s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
        forever begin
            @(negedge aclk); rdy = s_axis_tready;
            @(posedge aclk); #1;
            if (rdy) break;
            n++;
            if (n > 2000) begin
                n_chk++;
                $display("FAIL push_timeout: beat %0h not accepted after %0d cycles", d, n);
                break;
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic clr_log();
        log_d.delete(); log_l.delete(); log_c.delete();
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        m_tready = 1'b1;
        while (pkt_count != 0 && n < 500) begin step(1); n++; end
        chk(nm, pkt_count, 0);
        step(2);
    endtask

    int sent = 0;
    bit rnd_done = 0;

    initial begin
        int d, len;
        logic [7:0] lm;
        int lens [3] = '{1, 5, 2};

        step(2);
        rst = 1'b0;
        @(negedge aclk);
        chk("reset_tvalid", m_axis_tvalid, 0);
        chk("reset_pkt", pkt_count, 0);
        chk("reset_tready", s_axis_tready, 1);
        chk("reset_drop", drop_pulse, 0);
        step(1);

        // Single 4-beat packet, consumer always ready.
        clr_log(); m_tready = 1'b1;
        push(1, 0); push(2, 0); push(3, 0); push(4, 1);
        @(negedge aclk);
        chk("t1_valid_after_N", m_axis_tvalid, 0);
        chk("t1_pkt_after_N", pkt_count, 1);
        step(1);
        @(negedge aclk);
        chk("t1_valid_after_N1", m_axis_tvalid, 1);
        chk("t1_first_data", m_axis_tdata, 1);
        step(7);
        chk("t1_pkt_end", pkt_count, 0);
        chk("t1_nbeats", log_d.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_data", log_d[i], i + 1);
            chk("t1_last", log_l[i], (i == 3));
        end

        // Three packets stored, then released back to back.
        m_tready = 1'b0; pkt_max = 0; d = 16;
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < lens[p]; b++) begin push(d, b == lens[p] - 1); d++; end
        step(3);
        @(negedge aclk);
        chk("t2_pkt", pkt_count, 3);
        chk("t2_valid", m_axis_tvalid, 1);
        step(1);
        chk("t2_pkt_max", pkt_max, 3);
        clr_log(); m_tready = 1'b1;
        step(12);
        chk("t2_nbeats", log_d.size(), 8);
        chk("t2_span", log_c[7] - log_c[0], 7);
        lm = '0;
        for (int i = 0; i < 8; i++) lm[i] = (i < log_l.size()) ? log_l[i] : 1'b0;
        chk("t2_last_mask", lm, 8'b1010_0001);
        for (int i = 0; i < 8; i++) chk("t2_data", log_d[i], 16 + i);

        // Fill: one beat sits in the output register, so DEPTH+1 beats fill the RAM.
        clr_log(); m_tready = 1'b0; d = 100;
        for (int i = 0; i < 8; i++) begin push(d, i == 7); d++; end
        for (int i = 0; i < 9; i++) begin push(d, i == 8); d++; end
        @(negedge aclk); chk("t3_full_rdy", s_axis_tready, 0); step(1);
        @(negedge aclk); chk("t3_full_hold", s_axis_tready, 0); step(1);
        m_tready = 1'b1;
        @(negedge aclk); chk("t3_same_cycle_rdy", s_axis_tready, 0); step(1);
        m_tready = 1'b0;
        @(negedge aclk); chk("t3_rdy_restored", s_axis_tready, 1); step(1);
        drain("t3_drained");
        chk("t3_nbeats", log_d.size(), 17);
        for (int i = 0; i < 17; i++) chk("t3_data", log_d[i], 100 + i);

        // Random valid/ready over many pointer wraps.
        clr_log();
        fork
            begin
                while (sent < 10000) begin
                    len = $urandom_range(1, DEPTH);
                    for (int b = 0; b < len; b++) begin
                        while ($urandom_range(0, 1) == 1) step(1);
                        push($urandom, b == len - 1);
                        sent++;
                    end
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin m_tready = ($urandom_range(0, 1) == 1); step(1); end
            end
        join
        drain("t4_drained");
        chk("t4_nbeats", log_d.size(), sent);

        // Reset with one committed packet and a 3-beat partial stored.
        m_tready = 1'b0;
        push('h200, 0); push('h201, 1);
        push('h210, 0); push('h211, 0); push('h212, 0);
        step(2);
        rst = 1'b1; step(1); rst = 1'b0;
        @(negedge aclk);
        chk("t5_tvalid", m_axis_tvalid, 0);
        chk("t5_tdata", m_axis_tdata, 0);
        chk("t5_tlast", m_axis_tlast, 0);
        chk("t5_pkt", pkt_count, 0);
        chk("t5_tready", s_axis_tready, 1);
        chk("t5_drop", drop_pulse, 0);
        step(1);
        clr_log(); m_tready = 1'b1;
        push('h300, 0); push('h301, 0); push('h302, 1);
        step(8);
        chk("t5_nbeats", log_d.size(), 3);
        for (int i = 0; i < 3; i++) chk("t5_data", log_d[i], 'h300 + i);

`ifdef AXIS_PKT_DROP_OVERSIZE_EN
        clr_log(); pkt_max = 0; drop_cnt = 0; m_tready = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) push('h400 + i, i == DEPTH + 2);
        push('h500, 0); push('h501, 1);
        step(8);
        chk("t6_drop_cnt", drop_cnt, 1);
        chk("t6_pkt_max", pkt_max, 1);
        chk("t6_nbeats", log_d.size(), 2);
        chk("t6_data0", log_d[0], 'h500);
        chk("t6_data1", log_d[1], 'h501);
`else
        chk("drop_never", drop_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
